// File: rtl/zx_sram_arbiter_pkg.sv
// zx_bus_pkg: shared state encoding and bus defaults for the ZX SRAM arbiter.
package zx_bus_pkg;
    localparam int AW_DEF = 16;
    localparam int DW_DEF = 8;
    localparam logic [15:0] ROM_TOP_DEF = 16'h4000;
    typedef enum logic [1:0] {IDLE, VID_RD, CPU_RD, CPU_WR} state_t;
endpackage

// File: rtl/zx_sram_arbiter_if.sv
// zx_sram_arbiter_if: Z80 bus, video fetch port and SRAM controller port in one bundle.
interface zx_sram_arbiter_if import zx_bus_pkg::*; #(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) ();
    logic [AW-1:0] zaddr;
    logic [DW-1:0] zdo;
    logic          zwr;
    logic          zmreq;
    logic [DW-1:0] zdi;
    logic          zwait;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_ack;
    logic [DW-1:0] vid_data;
    logic          vid_valid;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic          sram_we;
    logic          sram_cs;
    logic [DW-1:0] sram_rdata;
    modport slave (
        input  zaddr, zdo, zwr, zmreq, vid_req, vid_addr, sram_rdata,
        output zdi, zwait, vid_ack, vid_data, vid_valid, sram_addr, sram_wdata, sram_we, sram_cs
    );
    modport master (
        output zaddr, zdo, zwr, zmreq, vid_req, vid_addr, sram_rdata,
        input  zdi, zwait, vid_ack, vid_data, vid_valid, sram_addr, sram_wdata, sram_we, sram_cs
    );
endinterface

// File: rtl/zx_sram_arbiter_starve_ctr.sv
// zx_starve_ctr: saturating count of VID grants taken while the CPU waits.
module zx_starve_ctr #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);
    logic [3:0] cnt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (inc && !at_limit) cnt <= cnt + 4'd1;
    end
    assign at_limit = cnt == 4'(LIMIT);
endmodule

// File: rtl/zx_sram_arbiter.sv
// zx_sram_arbiter: shares one synchronous SRAM between the NextZ80 and the video fetcher.
// Define ZX_ROM_PROTECT_EN to drop CPU writes below ROM_TOP.
module zx_sram_arbiter import zx_bus_pkg::*; #(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF,
    parameter int CPU_STARVE = 4,
    parameter logic [AW-1:0] ROM_TOP = AW'(ROM_TOP_DEF)
) (
    input logic clk,
    input logic reset,
    zx_sram_arbiter_if.slave bus
);
`ifdef ZX_ROM_PROTECT_EN
    localparam bit PROTECT = 1'b1;
`else
    localparam bit PROTECT = 1'b0;
`endif
    state_t        state;
    logic [AW-1:0] lat_addr;
    logic          lat_wr, served, cpu_cap, vid_cap, at_limit;
    logic [DW-1:0] zdi_q;
    logic          match, cpu_pend, cpu_done, hit, cpu_req, vid_go, cpu_go, rom_hit;
    assign match    = bus.zaddr == lat_addr && bus.zwr == lat_wr;
    assign cpu_pend = bus.zmreq & ~(served & match);
    // read data lands the cycle after CPU_RD, so completion is flagged from the capture stage
    assign cpu_done = cpu_cap | (state == CPU_WR);
    assign hit      = cpu_done & match;
    assign cpu_req  = cpu_pend & ~hit;
    assign vid_go   = state == IDLE && bus.vid_req && !(cpu_req && at_limit);
    assign cpu_go   = state == IDLE && !vid_go && cpu_req;
    assign rom_hit  = PROTECT && bus.zwr && bus.zaddr < ROM_TOP;
    assign bus.zwait = cpu_pend & ~hit & ~reset;
    assign bus.zdi   = cpu_cap ? bus.sram_rdata : zdi_q;
    zx_starve_ctr #(.LIMIT(CPU_STARVE)) u_starve (
        .clk(clk),
        .reset(reset),
        .inc(vid_go & cpu_pend),
        .clr((vid_go & ~cpu_pend) | cpu_go),
        .at_limit(at_limit)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            lat_addr       <= '0;
            lat_wr         <= 1'b0;
            served         <= 1'b0;
            cpu_cap        <= 1'b0;
            vid_cap        <= 1'b0;
            zdi_q          <= '0;
            bus.vid_ack    <= 1'b0;
            bus.vid_data   <= '0;
            bus.vid_valid  <= 1'b0;
            bus.sram_addr  <= '0;
            bus.sram_wdata <= '0;
            bus.sram_we    <= 1'b0;
            bus.sram_cs    <= 1'b0;
        end else begin
            vid_cap       <= state == VID_RD;
            cpu_cap       <= state == CPU_RD;
            bus.vid_valid <= vid_cap;
            if (vid_cap) bus.vid_data <= bus.sram_rdata;
            if (cpu_cap) zdi_q <= bus.sram_rdata;
            served        <= (served | cpu_done) & bus.zmreq & match;
            bus.vid_ack   <= vid_go;
            bus.sram_cs   <= vid_go | (cpu_go & ~rom_hit);
            bus.sram_we   <= cpu_go & bus.zwr & ~rom_hit;
            if (vid_go) bus.sram_addr <= bus.vid_addr;
            else if (cpu_go) begin
                bus.sram_addr  <= bus.zaddr;
                bus.sram_wdata <= bus.zdo;
                lat_addr       <= bus.zaddr;
                lat_wr         <= bus.zwr;
            end
            state <= vid_go ? VID_RD : cpu_go ? (bus.zwr ? CPU_WR : CPU_RD) : IDLE;
        end
    end
endmodule

// File: tb/tb_zx_sram_arbiter.sv
// tb_zx_sram_arbiter: directed checks of CPU/VID arbitration against a synchronous SRAM model.
module tb_zx_sram_arbiter;
    import zx_bus_pkg::*;
`ifdef ZX_ROM_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cs_cnt = 0;
    zx_sram_arbiter_if bus ();
    zx_sram_arbiter dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    function automatic logic [7:0] mem_rd(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h0A;
    endfunction
    always @(posedge clk) begin
        bus.sram_rdata <= (bus.sram_cs && !bus.sram_we) ? mem_rd(bus.sram_addr) : 8'h00;
        if (bus.sram_cs) cs_cnt <= cs_cnt + 1;
    end
    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic wait_done(input string tag);
        int n = 0;
        @(negedge clk);
        while (bus.zwait && n < 10) begin
            n++;
            @(negedge clk);
        end
        chk(tag, bus.zwait, 0);
    endtask
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int c0, acks, grants;
        logic done;
        bus.zaddr = '0; bus.zdo = '0; bus.zwr = 0; bus.zmreq = 1; bus.vid_req = 0; bus.vid_addr = '0;
        step();
        @(negedge clk);
        chk("reset_outs", {bus.zwait, bus.sram_cs, bus.sram_we, bus.vid_ack, bus.vid_valid}, 0);
        chk("reset_data", {bus.zdi, bus.vid_data, bus.sram_addr, bus.sram_wdata}, 0);
        bus.zmreq = 0;
        step(); reset = 0;
        step();
        // 1: uncontended CPU read
        c0 = cs_cnt;
        bus.zmreq = 1; bus.zaddr = 16'h0005; bus.zwr = 0;
        @(negedge clk); chk("t1_wait_c0", bus.zwait, 1);
        step(); @(negedge clk);
        chk("t1_wait_c1", bus.zwait, 1);
        chk("t1_sram", {bus.sram_cs, bus.sram_we, bus.sram_addr}, {1'b1, 1'b0, 16'h0005});
        step(); @(negedge clk);
        chk("t1_release", bus.zwait, 0);
        chk("t1_zdi", bus.zdi, 8'h0F);
        step(); bus.zmreq = 0;
        step(); step();
        chk("t1_zdi_hold", bus.zdi, 8'h0F);
        chk("t1_cs_count", cs_cnt - c0, 1);
        // 2: CPU write
        bus.zmreq = 1; bus.zwr = 1; bus.zaddr = 16'h8000; bus.zdo = 8'hAA;
        @(negedge clk); chk("t2_wait_c0", bus.zwait, 1);
        step(); @(negedge clk);
        chk("t2_sram", {bus.sram_cs, bus.sram_we, bus.sram_addr, bus.sram_wdata}, {1'b1, 1'b1, 16'h8000, 8'hAA});
        chk("t2_release", bus.zwait, 0);
        step(); @(negedge clk);
        chk("t2_we_pulse", {bus.sram_cs, bus.sram_we, bus.zwait}, 0);
        step(); bus.zmreq = 0; bus.zwr = 0;
        step();
        // 3: VID held against a pending CPU read
        acks = 0; grants = 0;
        bus.vid_req = 1; bus.vid_addr = 16'h2000; bus.zmreq = 1; bus.zaddr = 16'h0100;
        for (int c = 0; c < 60 && grants < 3; c++) begin
            @(negedge clk);
            done = !bus.zwait;
            if (bus.vid_ack) acks++;
            if (bus.vid_valid) chk("t3_vid_data", bus.vid_data, 8'h2A);
            if (bus.sram_cs && !bus.vid_ack) begin
                chk("t3_starve_window", acks, 4);
                acks = 0;
                grants++;
            end
            if (done) chk("t3_zdi", bus.zdi, mem_rd(bus.zaddr));
            step();
            if (done) bus.zaddr = bus.zaddr + 16'h1;
        end
        chk("t3_cpu_grants", grants, 3);
        bus.vid_req = 0;
        wait_done("t3_drain");
        step(); bus.zmreq = 0;
        step(); step();
        // 4: writes below and at the ROM boundary
        bus.zmreq = 1; bus.zwr = 1; bus.zaddr = 16'h1000; bus.zdo = 8'h55;
        step(); @(negedge clk);
        chk("t4_rom_cs", {bus.sram_cs, bus.sram_we}, {!PROT, !PROT});
        chk("t4_rom_release", bus.zwait, 0);
        step(); bus.zmreq = 0;
        step();
        bus.zmreq = 1; bus.zaddr = 16'h4000; bus.zdo = 8'h66;
        step(); @(negedge clk);
        chk("t4_ram_write", {bus.sram_cs, bus.sram_we, bus.sram_addr, bus.sram_wdata}, {1'b1, 1'b1, 16'h4000, 8'h66});
        step(); bus.zmreq = 0; bus.zwr = 0;
        step();
        // 5: reset while the CPU read is in flight
        bus.zmreq = 1; bus.zaddr = 16'h0033;
        step(); reset = 1;
        @(negedge clk);
        chk("t5_outs", {bus.zwait, bus.sram_cs, bus.sram_we, bus.vid_ack, bus.vid_valid}, 0);
        chk("t5_zdi", bus.zdi, 0);
        step(); @(negedge clk);
        chk("t5_outs_edge", {bus.zwait, bus.sram_cs, bus.vid_valid, bus.zdi}, 0);
        bus.zmreq = 0; reset = 0;
        step(); step(); step();
        chk("t5_no_zdi_update", bus.zdi, 0);
        // 6: zmreq held while the address steps after completion
        c0 = cs_cnt;
        bus.zmreq = 1; bus.zaddr = 16'h0000;
        wait_done("t6_done0");
        chk("t6_zdi0", bus.zdi, 8'h0A);
        step(); step(); step();
        chk("t6_served_wait", bus.zwait, 0);
        bus.zaddr = 16'h0001;
        @(negedge clk); chk("t6_new_pend", bus.zwait, 1);
        wait_done("t6_done1");
        chk("t6_zdi1", bus.zdi, 8'h0B);
        step(); step(); step();
        bus.zmreq = 0;
        step(); step();
        chk("t6_cs_count", cs_cnt - c0, 2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
